// File: rtl/rms_pkg.sv
// Shared definitions for the rms_framed register management subsystem.
//   - regsrc encodings for the port-2 write data select
//   - call-frame FSM state type
//   - default addresses of the condition and IO registers
package rms_pkg;

  // Port-2 write data select (regsrc)
  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_RA  = 2'd3;

  localparam int unsigned CR_ADDR_DEFAULT = 57;
  localparam int unsigned IO_ADDR_DEFAULT = 63;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StRestore
  } frame_state_e;

endpackage

// File: rtl/frame_stack.sv
// Hardware call-frame stack for rms_framed.
// Holds STACK_DEPTH frames of FRAME_REGS words each, plus the stack pointer.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears sp and storage)
//   wr_en, wr_idx,  write word wr_idx of the frame at sp (the frame being pushed)
//   wr_data
//   push, pop       sp increment / decrement (ignored when full / empty)
//   rd_idx, rd_data combinational read of word rd_idx of the top frame (sp-1)
//   full, empty     sp == STACK_DEPTH / sp == 0
module frame_stack #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_REGS  = 15,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned IDX_W       = (FRAME_REGS > 1) ? $clog2(FRAME_REGS) : 1,
  parameter int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned Entries = STACK_DEPTH * FRAME_REGS;
  localparam int unsigned MemAw   = (Entries > 1) ? $clog2(Entries) : 1;

  logic [DATA_W-1:0] mem_q [Entries];
  logic [SP_W-1:0]   sp_q;
  logic [MemAw-1:0]  wr_addr;
  logic [MemAw-1:0]  rd_addr;

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);

  // Frames are laid out contiguously: frame n occupies [n*FRAME_REGS, (n+1)*FRAME_REGS).
  assign wr_addr = MemAw'(32'(sp_q) * FRAME_REGS + 32'(wr_idx));
  // Only meaningful while sp > 0; the FSM never restores from an empty stack.
  assign rd_addr = MemAw'((32'(sp_q) - 32'd1) * FRAME_REGS + 32'(rd_idx));
  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Entries); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && !full) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/rms_framed.sv
// Register management subsystem with an internal call-frame stack.
// Register file of 2^ADDR_W x DATA_W with two combinational read ports and two
// write ports, a CR write path, a memory-mapped IO register and a registered
// comparator. A save/restore FSM spills/fills FRAME_REGS registers starting at
// FRAME_BASE into/out of frame_stack, one register per cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ir                         [15:12] opcode, [11:6] dest/src1, [5:0] src2
//   imm_in, w2_alu, w2_mem     port-2 write data sources (regsrc 0/1/2)
//   altb                       port-1 write data (zero-extended)
//   write_cr                   port-1/read-A address = CR_ADDR instead of ir[11:6]
//   regsrc                     port-2 data select (3 = read port A value)
//   reg_r1, reg_r2             read enables (disabled port reads 0)
//   reg_w1, reg_w2             write enables (port 2 wins on address clash)
//   save_req, restore_req      frame push / pop requests
//   cmp_eq, cmp_ne             comparator strobes (eq has priority)
//   io_in                      value returned on reads of IO_ADDR
//   op                         ir[15:12]
//   a, b                       read data for port-1 address / ir[5:0]
//   cmp_result                 registered compare result
//   io_out                     IO register contents
//   busy                       frame FSM active
//   stack_full, stack_empty    frame stack status
//   frame_err                  one-cycle pulse, the cycle after an illegal request
module rms_framed
  import rms_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned FRAME_BASE  = 1,
  parameter int unsigned FRAME_REGS  = 15,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned CR_ADDR     = CR_ADDR_DEFAULT,
  parameter int unsigned IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ir,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] w2_alu,
  input  logic [DATA_W-1:0] w2_mem,
  input  logic              altb,
  input  logic              write_cr,
  input  logic [1:0]        regsrc,
  input  logic              reg_r1,
  input  logic              reg_r2,
  input  logic              reg_w1,
  input  logic              reg_w2,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              cmp_eq,
  input  logic              cmp_ne,
  input  logic [DATA_W-1:0] io_in,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              cmp_result,
  output logic [DATA_W-1:0] io_out,
  output logic              busy,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              frame_err
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned IdxW    = (FRAME_REGS > 1) ? $clog2(FRAME_REGS) : 1;
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(FRAME_REGS - 1);
  localparam logic [ADDR_W-1:0] CrAddr  = ADDR_W'(CR_ADDR);
  localparam logic [ADDR_W-1:0] IoAddr  = ADDR_W'(IO_ADDR);

  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [DATA_W-1:0] rf_d [NumRegs];

  frame_state_e      state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              frame_err_q, frame_err_d;
  logic              cmp_q;

  logic [ADDR_W-1:0] addr_w1, addr_w2, addr_b, frame_addr;
  logic [DATA_W-1:0] wdata2;
  logic [DATA_W-1:0] stack_rd;
  logic              stack_push, stack_pop, stack_wr, restore_wr;

  function automatic logic in_frame(input logic [ADDR_W-1:0] ad);
    return (32'(ad) >= FRAME_BASE) && (32'(ad) < FRAME_BASE + FRAME_REGS);
  endfunction

  assign op         = ir[15:12];
  assign addr_w2    = ADDR_W'(ir[11:6]);
  assign addr_w1    = write_cr ? CrAddr : addr_w2;  // also the read-port A address
  assign addr_b     = ADDR_W'(ir[5:0]);
  assign frame_addr = ADDR_W'(FRAME_BASE + 32'(idx_q));

  assign busy       = (state_q != StIdle);
  assign io_out     = rf_q[IoAddr];
  assign frame_err  = frame_err_q;
  assign cmp_result = cmp_q;

  // Read ports: no write bypass, IO address returns the external input.
  always_comb begin
    a = '0;
    if (reg_r1) begin
      if (addr_w1 == '0)        a = '0;
      else if (addr_w1 == IoAddr) a = io_in;
      else                      a = rf_q[addr_w1];
    end
  end

  always_comb begin
    b = '0;
    if (reg_r2) begin
      if (addr_b == '0)        b = '0;
      else if (addr_b == IoAddr) b = io_in;
      else                     b = rf_q[addr_b];
    end
  end

  always_comb begin
    wdata2 = imm_in;
    case (regsrc)
      SRC_IMM: wdata2 = imm_in;
      SRC_ALU: wdata2 = w2_alu;
      SRC_MEM: wdata2 = w2_mem;
      SRC_RA:  wdata2 = a;
      default: wdata2 = imm_in;
    endcase
  end

  // Register file next state. The frame window is owned by the FSM while busy,
  // so user writes there are dropped and cannot collide with restore writes.
  always_comb begin
    rf_d = rf_q;
    if (reg_w1 && (addr_w1 != '0) && !(busy && in_frame(addr_w1))) begin
      rf_d[addr_w1] = {{(DATA_W-1){1'b0}}, altb};
    end
    if (reg_w2 && (addr_w2 != '0) && !(busy && in_frame(addr_w2))) begin
      rf_d[addr_w2] = wdata2;
    end
    if (restore_wr) begin
      rf_d[frame_addr] = stack_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Frame FSM: next state and control
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_wr    = 1'b0;
    restore_wr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (save_req && restore_req) begin
          frame_err_d = 1'b1;
        end else if (save_req) begin
          if (stack_full) begin
            frame_err_d = 1'b1;
          end else begin
            state_d = StSave;
            idx_d   = '0;
          end
        end else if (restore_req) begin
          if (stack_empty) begin
            frame_err_d = 1'b1;
          end else begin
            state_d = StRestore;
            idx_d   = '0;
          end
        end
      end
      StSave: begin
        stack_wr = 1'b1;
        if (idx_q == LastIdx) begin
          stack_push = 1'b1;
          state_d    = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StRestore: begin
        restore_wr = 1'b1;
        if (idx_q == LastIdx) begin
          stack_pop = 1'b1;
          state_d   = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= 1'b0;
    end else if (cmp_eq) begin
      cmp_q <= (a == b);
    end else if (cmp_ne) begin
      cmp_q <= (a != b);
    end
  end

  frame_stack #(
    .DATA_W      (DATA_W),
    .FRAME_REGS  (FRAME_REGS),
    .STACK_DEPTH (STACK_DEPTH),
    .IDX_W       (IdxW)
  ) u_frame_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (stack_wr),
    .wr_idx  (idx_q),
    .wr_data (rf_q[frame_addr]),
    .push    (stack_push),
    .pop     (stack_pop),
    .rd_idx  (idx_q),
    .rd_data (stack_rd),
    .full    (stack_full),
    .empty   (stack_empty)
  );

endmodule
